if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS core, directly upstream of `datapath` decode. It owns the PC and issues word fetches on an SRAM-like instruction-memory port. It buffers returned instructions in a small FIFO and presents them, paired with their PC, to decode through a valid/ready handshake. Branch and jump redirects from `datapath` flush the buffer and discard fetches already in flight.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/if_stage_if.sv | 25 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/if_stage.sv | 134 +++++++++++++
 tb/tb_if_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the MIPS core front end.
//   RESET_PC_DEFAULT : first fetch address after reset (boot ROM vector)
//   INST_W / ADDR_W  : instruction and address widths
//   fetch_entry_t    : {pc, inst} pair buffered between fetch and decode
//   next_pc()        : sequential fetch address, wraps modulo 2^32
package cpu_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;

  localparam addr_t RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fetch_entry_t;

  function automatic addr_t next_pc(input addr_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: SRAM-like instruction-memory port.
//   inst_req/inst_addr        : fetch request and byte address (fetch side)
//   inst_addr_ok              : request accepted this cycle (memory side)
//   inst_data_ok/inst_rdata   : in-order response (memory side)
// modport master = fetch stage, modport slave = instruction memory.
interface if_stage_if;
  import cpu_pkg::*;

  logic  inst_req;
  addr_t inst_addr;
  logic  inst_addr_ok;
  logic  inst_data_ok;
  inst_t inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage.
//   clk, rst_n        : clock, async active-low reset
//   push, push_data   : write when push is high (caller guarantees space)
//   pop               : drop head when high (caller guarantees non-empty)
//   flush             : empty the FIFO; overrides push/pop
//   head              : current head entry (stale when count == 0)
//   count             : number of stored entries
module sync_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC, issues word fetches on the
// instruction-memory port, buffers returned words with their PC and hands
// them to decode over valid/ready. Redirects flush the buffer and drop
// fetches already in flight.
//   clk, rst                 : clock, async-assert active-low reset
//   imem (master)            : instruction-memory request/response port
//   redirect_valid/_pc       : one-cycle flush-and-restart from datapath
//   id_valid/id_pc/id_inst   : buffer head presented to decode
//   id_ready                 : decode consumes head on id_valid && id_ready
module if_stage
  import cpu_pkg::*;
#(
  parameter addr_t       RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  if_stage_if.master    imem,
  input  logic          redirect_valid,
  input  addr_t         redirect_pc,
  output logic          id_valid,
  output addr_t         id_pc,
  output inst_t         id_inst,
  input  logic          id_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = $bits(fetch_entry_t);

  addr_t        fetch_pc_q, fetch_pc_d;
  logic         pending_q, pending_d;
  logic [CW-1:0] discard_q, discard_d;
  logic         redir_pend_q, redir_pend_d;
  addr_t        redir_pc_q, redir_pc_d;
  fetch_entry_t hold_q, hold_d;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_cnt;
  logic [ADDR_W-1:0] tag_head;
  logic [EW-1:0] out_head_raw;
  fetch_entry_t  out_head, out_push;

  logic credit, req, accept, data_ok, keep, handshake;

  // Accepted-but-unanswered requests; its occupancy is the outstanding count.
  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
    .clk       (clk),
    .rst_n     (rst),
    .push      (accept),
    .push_data (fetch_pc_q),
    .pop       (data_ok),
    .flush     (1'b0),
    .head      (tag_head),
    .count     (outstanding)
  );

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_out_q (
    .clk       (clk),
    .rst_n     (rst),
    .push      (keep),
    .push_data (out_push),
    .pop       (handshake),
    .flush     (redirect_valid),
    .head      (out_head_raw),
    .count     (out_cnt)
  );

  assign out_head = fetch_entry_t'(out_head_raw);
  assign out_push = '{pc: tag_head, inst: imem.inst_rdata};

  // Discarded responses still hold credit until they return.
  assign credit  = ({1'b0, outstanding} + {1'b0, out_cnt}) < (CW+1)'(DEPTH);
  // Gated by rst so the request drops the instant reset asserts.
  assign req     = rst && (pending_q || (credit && !redirect_valid));
  assign accept  = req && imem.inst_addr_ok;
  assign data_ok = imem.inst_data_ok;
  assign keep    = data_ok && !redirect_valid && (discard_q == '0);

  assign imem.inst_req  = req;
  assign imem.inst_addr = fetch_pc_q;

  assign id_valid  = (out_cnt != '0);
  assign handshake = id_valid && id_ready;
  assign id_pc     = id_valid ? out_head.pc   : hold_q.pc;
  assign id_inst   = id_valid ? out_head.inst : hold_q.inst;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_d    = req && !accept;
    discard_d    = discard_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    hold_d       = id_valid ? out_head : hold_q;

    if (redirect_valid) begin
      discard_d = outstanding + CW'(accept) - CW'(data_ok);
      if (pending_q && !accept) begin
        // Request must stay stable: restart address is applied on accept,
        // and that accepted fetch is added to discard then.
        redir_pend_d = 1'b1;
        redir_pc_d   = redirect_pc;
      end else begin
        fetch_pc_d   = redirect_pc;
        redir_pend_d = 1'b0;
      end
    end else begin
      if (accept) begin
        fetch_pc_d   = redir_pend_q ? redir_pc_q : next_pc(fetch_pc_q);
        redir_pend_d = 1'b0;
      end
      discard_d = discard_q + CW'(accept && redir_pend_q)
                            - CW'(data_ok && (discard_q != '0));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      discard_q    <= '0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
      hold_q       <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      discard_q    <= discard_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      hold_q       <= hold_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import cpu_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  redirect_valid = 1'b0;
  addr_t redirect_pc = '0;
  logic  id_valid;
  addr_t id_pc;
  inst_t id_inst;
  logic  id_ready = 1'b0;
  logic  accept_en = 1'b0;
  logic  resp_en = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_stage_if mif();

  if_stage #(.RESET_PC(32'hBFC0_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (mif),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_ready       (id_ready)
  );

  // Memory model: accepts when enabled, answers in order no sooner than the
  // next cycle; returned word is {addr[15:0], 16'hC0DE}.
  logic [31:0] mq [8];
  logic [2:0]  mhead, mtail;
  logic [3:0]  mcnt;
  int          acc_cnt, hs_cnt;

  assign mif.inst_addr_ok = mif.inst_req && accept_en;
  assign mif.inst_data_ok = resp_en && (mcnt != 4'd0);
  assign mif.inst_rdata   = {mq[mhead][15:0], 16'hC0DE};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mhead <= '0; mtail <= '0; mcnt <= '0;
      acc_cnt <= 0; hs_cnt <= 0;
    end else begin
      if (mif.inst_addr_ok) begin
        mq[mtail] <= mif.inst_addr;
        mtail <= mtail + 3'd1;
        acc_cnt <= acc_cnt + 1;
      end
      if (mif.inst_data_ok) mhead <= mhead + 3'd1;
      mcnt <= mcnt + {3'b0, mif.inst_addr_ok} - {3'b0, mif.inst_data_ok};
      if (id_valid && id_ready) hs_cnt <= hs_cnt + 1;
    end
  end

  task automatic apply_reset(input logic acc, input logic rsp, input logic rdy);
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    accept_en = acc; resp_en = rsp; id_ready = rdy;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; accept_en = 1'b1; resp_en = 1'b1; id_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mif.inst_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", mif.inst_req); end
    checks++; if (mif.inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL rst_addr got=%h exp=bfc00000", mif.inst_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", id_valid); end
    checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", id_pc); end
    checks++; if (id_inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", id_inst); end
  endtask

  task automatic test_stream;
    apply_reset(1'b1, 1'b1, 1'b1);
    checks++; if (mif.inst_req !== 1'b1) begin failures++; $display("FAIL str_req0 got=%0b exp=1", mif.inst_req); end
    checks++; if (mif.inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL str_addr0 got=%h exp=bfc00000", mif.inst_addr); end
    @(negedge clk);
    checks++; if (mif.inst_addr !== 32'hBFC00004) begin failures++; $display("FAIL str_addr1 got=%h exp=bfc00004", mif.inst_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL str_early_valid got=%0b exp=0", id_valid); end
    @(negedge clk);
    checks++; if (mif.inst_addr !== 32'hBFC00008) begin failures++; $display("FAIL str_addr2 got=%h exp=bfc00008", mif.inst_addr); end
    checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL str_valid0 got=%0b exp=1", id_valid); end
    checks++; if (id_pc !== 32'hBFC00000) begin failures++; $display("FAIL str_pc0 got=%h exp=bfc00000", id_pc); end
    checks++; if (id_inst !== 32'h0000C0DE) begin failures++; $display("FAIL str_inst0 got=%h exp=0000c0de", id_inst); end
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC00004) begin failures++; $display("FAIL str_pc1 got=%0b/%h exp=1/bfc00004", id_valid, id_pc); end
    checks++; if (id_inst !== 32'h0004C0DE) begin failures++; $display("FAIL str_inst1 got=%h exp=0004c0de", id_inst); end
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC00008) begin failures++; $display("FAIL str_pc2 got=%0b/%h exp=1/bfc00008", id_valid, id_pc); end
    checks++; if (id_inst !== 32'h0008C0DE) begin failures++; $display("FAIL str_inst2 got=%h exp=0008c0de", id_inst); end
  endtask

  task automatic test_backpressure;
    apply_reset(1'b1, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    checks++; if (acc_cnt !== 4) begin failures++; $display("FAIL bp_accepts got=%0d exp=4", acc_cnt); end
    checks++; if (mif.inst_req !== 1'b0) begin failures++; $display("FAIL bp_req_full got=%0b exp=0", mif.inst_req); end
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC00000) begin failures++; $display("FAIL bp_head got=%0b/%h exp=1/bfc00000", id_valid, id_pc); end
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (acc_cnt !== 5) begin failures++; $display("FAIL bp_one_more got=%0d exp=5", acc_cnt); end
    checks++; if (mif.inst_req !== 1'b0) begin failures++; $display("FAIL bp_req_refull got=%0b exp=0", mif.inst_req); end
    checks++; if (id_pc !== 32'hBFC00004) begin failures++; $display("FAIL bp_head2 got=%h exp=bfc00004", id_pc); end
  endtask

  task automatic test_redirect_outstanding;
    int n;
    apply_reset(1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (acc_cnt !== 2) begin failures++; $display("FAIL ro_accepts got=%0d exp=2", acc_cnt); end
    accept_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80000100;
    #1;
    checks++; if (mif.inst_req !== 1'b0) begin failures++; $display("FAIL ro_req_redir got=%0b exp=0", mif.inst_req); end
    @(negedge clk);
    redirect_valid = 1'b0; accept_en = 1'b1; resp_en = 1'b1;
    #1;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL ro_valid_after got=%0b exp=0", id_valid); end
    checks++; if (mif.inst_req !== 1'b1 || mif.inst_addr !== 32'h80000100) begin failures++; $display("FAIL ro_new_addr got=%0b/%h exp=1/80000100", mif.inst_req, mif.inst_addr); end
    n = 0;
    while (id_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL ro_wait got=%0b exp=1", id_valid); end
    checks++; if (id_pc !== 32'h80000100) begin failures++; $display("FAIL ro_pc got=%h exp=80000100", id_pc); end
    checks++; if (id_inst !== 32'h0100C0DE) begin failures++; $display("FAIL ro_inst got=%h exp=0100c0de", id_inst); end
  endtask

  task automatic test_redirect_pending;
    int n;
    apply_reset(1'b0, 1'b1, 1'b1);
    checks++; if (mif.inst_req !== 1'b1 || mif.inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL rp_req0 got=%0b/%h exp=1/bfc00000", mif.inst_req, mif.inst_addr); end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h80000200;
    #1;
    checks++; if (mif.inst_req !== 1'b1 || mif.inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL rp_hold1 got=%0b/%h exp=1/bfc00000", mif.inst_req, mif.inst_addr); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (mif.inst_req !== 1'b1 || mif.inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL rp_hold2 got=%0b/%h exp=1/bfc00000", mif.inst_req, mif.inst_addr); end
    @(negedge clk);
    checks++; if (mif.inst_req !== 1'b1 || mif.inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL rp_hold3 got=%0b/%h exp=1/bfc00000", mif.inst_req, mif.inst_addr); end
    accept_en = 1'b1;
    @(negedge clk);
    checks++; if (acc_cnt !== 1) begin failures++; $display("FAIL rp_accepts got=%0d exp=1", acc_cnt); end
    checks++; if (mif.inst_req !== 1'b1 || mif.inst_addr !== 32'h80000200) begin failures++; $display("FAIL rp_new_addr got=%0b/%h exp=1/80000200", mif.inst_req, mif.inst_addr); end
    n = 0;
    while (id_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL rp_wait got=%0b exp=1", id_valid); end
    checks++; if (id_pc !== 32'h80000200) begin failures++; $display("FAIL rp_pc got=%h exp=80000200", id_pc); end
    checks++; if (id_inst !== 32'h0200C0DE) begin failures++; $display("FAIL rp_inst got=%h exp=0200c0de", id_inst); end
  endtask

  task automatic test_redirect_same_cycle;
    int n;
    apply_reset(1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC00000) begin failures++; $display("FAIL sc_head got=%0b/%h exp=1/bfc00000", id_valid, id_pc); end
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80000300;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (hs_cnt !== 1) begin failures++; $display("FAIL sc_handshake got=%0d exp=1", hs_cnt); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL sc_flushed got=%0b exp=0", id_valid); end
    checks++; if (mif.inst_req !== 1'b1 || mif.inst_addr !== 32'h80000300) begin failures++; $display("FAIL sc_new_addr got=%0b/%h exp=1/80000300", mif.inst_req, mif.inst_addr); end
    n = 0;
    while (id_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h80000300) begin failures++; $display("FAIL sc_first got=%0b/%h exp=1/80000300", id_valid, id_pc); end
    checks++; if (id_inst !== 32'h0300C0DE) begin failures++; $display("FAIL sc_inst got=%h exp=0300c0de", id_inst); end
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h80000304) begin failures++; $display("FAIL sc_second got=%0b/%h exp=1/80000304", id_valid, id_pc); end
  endtask

  task automatic test_reset_midstream;
    int n;
    apply_reset(1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    accept_en = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (id_valid !== 1'b1 || mif.inst_req !== 1'b1) begin failures++; $display("FAIL mr_pre got=%0b/%0b exp=1/1", id_valid, mif.inst_req); end
    checks++; if (id_pc !== 32'hBFC00000) begin failures++; $display("FAIL mr_pre_pc got=%h exp=bfc00000", id_pc); end
    rst = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL mr_valid got=%0b exp=0", id_valid); end
    checks++; if (mif.inst_req !== 1'b0) begin failures++; $display("FAIL mr_req got=%0b exp=0", mif.inst_req); end
    checks++; if (mif.inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL mr_addr got=%h exp=bfc00000", mif.inst_addr); end
    repeat (2) @(negedge clk);
    accept_en = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (mif.inst_req !== 1'b1 || mif.inst_addr !== 32'hBFC00000) begin failures++; $display("FAIL mr_restart got=%0b/%h exp=1/bfc00000", mif.inst_req, mif.inst_addr); end
    n = 0;
    while (id_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC00000) begin failures++; $display("FAIL mr_first got=%0b/%h exp=1/bfc00000", id_valid, id_pc); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_outstanding;
    test_redirect_pending;
    test_redirect_same_cycle;
    test_reset_midstream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
